// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
// Each grant carries a burst that ends on req_last, after MAX_BURST words, or when the owner goes idle.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned   GW        = $clog2(NUM_REQ);
    localparam int unsigned   BW        = $clog2(MAX_BURST) + 1;
    localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           grant_nxt;
    logic [BW-1:0]           beat_cnt, beat_nxt;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   words [NUM_REQ];
    logic [DATA_WIDTH-1:0]   gword;
    logic                    gvalid;
    logic                    found;
    int unsigned             idx;
    logic [GW-1:0]           idx_g;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
        assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign gword  = words[grant_id];
    assign gvalid = req_valid[grant_id];

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state    <= IDLE;
            grant_id <= GRANT_RST;
            beat_cnt <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
            if (state == BURST)
                wdata_q <= gword;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        beat_nxt  = beat_cnt;
        found     = 1'b0;
        idx       = 0;
        idx_g     = '0;
        unique case (state)
            IDLE: begin
                // Search starts one past the last owner, so a released producer goes to the back.
                for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                    idx   = (32'(grant_id) + k) % NUM_REQ;
                    idx_g = GW'(idx);
                    if (!found && req_valid[idx_g]) begin
                        found     = 1'b1;
                        grant_nxt = idx_g;
                    end
                end
                if (found) begin
                    state_nxt = BURST;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                if (winc) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (req_last[grant_id] || beat_cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end
                end else if (!gvalid) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end
            end
        endcase
    end

    always_comb begin
        winc      = 1'b0;
        req_ready = '0;
        wdata     = wdata_q;
        busy      = 1'b0;
        if (state == BURST) begin
            busy                = 1'b1;
            wdata               = gword;
            winc                = gvalid & ~wfull;
            req_ready[grant_id] = winc;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level model of ownership, burst length and round-robin order.
module tb_fifo_wr_arbiter;

    localparam int NR = 3;
    localparam int DW = 8;
    localparam int MB = 4;

    logic             wclk = 1'b0;
    logic             wrst;
    logic [NR-1:0]    req_valid, req_last, req_ready;
    logic [NR*DW-1:0] req_data;
    logic             wfull, winc, busy;
    logic [DW-1:0]    wdata;
    logic [1:0]       grant_id;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int          total = 0;
    int          bad   = 0;
    logic [8:0]  pbuf [NR][64];
    int          head [NR];
    int          tail [NR];
    logic [NR-1:0] drop;
    int          owner, last_g, nbeats;
    logic [DW-1:0] last_wdata;
    int          cyc;
    logic [63:0] winc_tr, busy_tr;
    int          grant_tr [64];
    logic [31:0] wlog;
    int          wcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int r);
        return req_data[r*DW +: DW];
    endfunction

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < NR; r++) n += tail[r] - head[r];
        return n;
    endfunction

    task automatic push(input int r, input logic [DW-1:0] d, input logic l);
        pbuf[r][tail[r] % 64] = {l, d};
        tail[r]++;
    endtask

    task automatic apply_inputs();
        for (int r = 0; r < NR; r++) begin
            if (head[r] != tail[r]) begin
                logic [8:0] e;
                e = pbuf[r][head[r] % 64];
                req_valid[r]        = ~drop[r];
                req_last[r]         = e[8];
                req_data[r*DW +: DW] = e[7:0];
            end else begin
                req_valid[r]        = 1'b0;
                req_last[r]         = 1'($urandom_range(0, 1));
                req_data[r*DW +: DW] = 8'($urandom);
            end
        end
    endtask

    // One clock: drive after negedge, check mid-cycle, advance model at posedge.
    task automatic cycle();
        logic          e_winc, e_busy;
        logic [NR-1:0] e_ready;
        logic [DW-1:0] e_wdata;
        int            e_grant;
        apply_inputs();
        #1;
        if (wrst) begin
            e_winc = 1'b0; e_busy = 1'b0; e_ready = '0; e_wdata = '0; e_grant = NR - 1;
            owner = -1; last_g = NR - 1; last_wdata = '0; nbeats = 0;
        end else if (owner < 0) begin
            e_winc = 1'b0; e_busy = 1'b0; e_ready = '0; e_wdata = last_wdata; e_grant = last_g;
        end else begin
            e_busy  = 1'b1;
            e_winc  = req_valid[owner] && !wfull;
            e_ready = e_winc ? NR'(1 << owner) : '0;
            e_wdata = word_of(owner);
            e_grant = owner;
        end
        chk("winc", 32'(winc), 32'(e_winc));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("wdata", 32'(wdata), 32'(e_wdata));
        chk("grant_id", 32'(grant_id), 32'(e_grant));
        if (cyc < 64) begin
            winc_tr[cyc]  = winc;
            busy_tr[cyc]  = busy;
            grant_tr[cyc] = int'(grant_id);
        end
        if (winc) begin
            wlog = {wlog[23:0], wdata};
            wcnt++;
        end
        @(posedge wclk);
        if (!wrst) begin
            if (owner < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    int i;
                    i = (last_g + k) % NR;
                    if (owner < 0 && req_valid[i]) begin
                        owner = i; last_g = i; nbeats = 0;
                    end
                end
            end else begin
                last_wdata = word_of(owner);
                if (e_winc) begin
                    nbeats++;
                    head[owner]++;
                    if (req_last[owner] || nbeats == MB) owner = -1;
                end else if (!req_valid[owner]) begin
                    owner = -1;
                end
            end
        end
        cyc++;
        @(negedge wclk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        wrst = 1'b1; wfull = 1'b0; drop = '0;
        for (int r = 0; r < NR; r++) begin head[r] = 0; tail[r] = 0; end
        cycle();
        wrst = 1'b0;
        cyc = 0; winc_tr = '0; busy_tr = '0; wlog = '0; wcnt = 0;
    endtask

    task automatic drain();
        int guard = 0;
        wfull = 1'b0; drop = '0;
        while (pending() > 0 && guard < 300) begin
            cycle();
            guard++;
        end
        chk("drain_left", 32'(pending()), 32'd0);
    endtask

    initial begin
        wrst = 1'b1; wfull = 1'b0; drop = '0;
        req_valid = '0; req_last = '0; req_data = '0;
        owner = -1; last_g = NR - 1; nbeats = 0; last_wdata = '0; cyc = 0;
        for (int r = 0; r < NR; r++) begin head[r] = 0; tail[r] = 0; end
        @(negedge wclk);

        // 1: single producer, three words ending in last
        do_reset();
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        run(5);
        chk("t1_winc_trace", 32'(winc_tr[4:0]), 32'b01110);
        chk("t1_words", wlog, 32'h00A1A2A3);
        chk("t1_grant", 32'(grant_tr[3]), 32'd0);
        chk("t1_idle_after", 32'(busy_tr[4]), 32'd0);

        // 2: two always-valid producers, bursts capped at MAX_BURST
        do_reset();
        for (int n = 0; n < 12; n++) begin
            push(0, 8'(8'h10 + n), 1'b0);
            push(1, 8'(8'h40 + n), 1'b0);
        end
        run(15);
        chk("t2_winc_trace", 32'(winc_tr[14:0]), 32'b111101111011110);
        chk("t2_grant_a", 32'(grant_tr[2]), 32'd0);
        chk("t2_grant_b", 32'(grant_tr[7]), 32'd1);
        chk("t2_grant_c", 32'(grant_tr[12]), 32'd0);
        drain();

        // 3: wfull stall after the second word of a req1 burst
        do_reset();
        push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b0); push(1, 8'h34, 1'b1);
        run(3);
        wfull = 1'b1;
        run(3);
        wfull = 1'b0;
        run(3);
        chk("t3_winc_trace", 32'(winc_tr[8:0]), 32'b011000110);
        chk("t3_count", 32'(wcnt), 32'd4);
        chk("t3_words", wlog, 32'h31323334);

        // 4: req0 goes idle mid-burst, req1 waiting
        do_reset();
        push(0, 8'h51, 1'b0);
        push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
        run(7);
        chk("t4_winc_trace", 32'(winc_tr[6:0]), 32'b0110010);
        chk("t4_busy_trace", 32'(busy_tr[6:0]), 32'b0110110);
        chk("t4_grant", 32'(grant_tr[4]), 32'd1);

        // 5: reset in the middle of a burst
        do_reset();
        for (int n = 0; n < 8; n++) begin
            push(0, 8'(8'h70 + n), 1'b0);
            push(1, 8'(8'h90 + n), 1'b0);
        end
        run(3);
        wrst = 1'b1;
        cycle();
        wrst = 1'b0;
        cyc = 0;
        run(2);
        chk("t5_arb_idle", 32'(busy_tr[0]), 32'd0);
        chk("t5_first_grant", 32'(grant_tr[1]), 32'd0);
        chk("t5_first_write", 32'(winc_tr[1]), 32'd1);
        drain();

        // 6: three producers, single-word bursts
        do_reset();
        push(0, 8'hC0, 1'b1); push(0, 8'hC3, 1'b1);
        push(1, 8'hC1, 1'b1); push(2, 8'hC2, 1'b1);
        run(8);
        chk("t6_winc_trace", 32'(winc_tr[7:0]), 32'b10101010);
        chk("t6_g0", 32'(grant_tr[1]), 32'd0);
        chk("t6_g1", 32'(grant_tr[3]), 32'd1);
        chk("t6_g2", 32'(grant_tr[5]), 32'd2);
        chk("t6_g3", 32'(grant_tr[7]), 32'd0);

        // random traffic with backpressure, valid drops and occasional reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NR; r++)
                if (tail[r] - head[r] < 4 && $urandom_range(0, 2) == 0)
                    push(r, 8'($urandom), 1'($urandom_range(0, 3) == 0));
            wfull = ($urandom_range(0, 4) == 0);
            for (int r = 0; r < NR; r++) drop[r] = ($urandom_range(0, 15) == 0);
            wrst  = ($urandom_range(0, 149) == 0);
            cycle();
        end
        wrst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
